// File: rtl/lisnoc16_usb_tx_framer_pkg.sv
// Shared definitions for the 16-bit LISNoC USB transmit framer: flit field
// bounds, flit type codes, flit payload struct and framer widths.
// Ports: none (package only).
package lisnoc16_usb_tx_framer_pkg;

    localparam int unsigned FLIT16_WIDTH       = 18;
    localparam int unsigned FLIT16_TYPE_MSB    = 17;
    localparam int unsigned FLIT16_TYPE_LSB    = 16;
    localparam int unsigned FLIT16_CONTENT_MSB = 15;
    localparam int unsigned FLIT16_CONTENT_LSB = 0;
    localparam int unsigned FLIT16_CONTENT_W   = 16;
    localparam int unsigned LEN_WIDTH          = 8;
    localparam int unsigned BYTE_WIDTH         = 8;

    typedef enum logic [1:0] {
        FLIT16_TYPE_PAYLOAD = 2'b00,
        FLIT16_TYPE_HEADER  = 2'b01,
        FLIT16_TYPE_LAST    = 2'b10,
        FLIT16_TYPE_SINGLE  = 2'b11
    } flit16_type_e;

    typedef struct packed {
        flit16_type_e                ftype;
        logic [FLIT16_CONTENT_W-1:0] content;
    } flit16_t;

    // Address width for a buffer of the given depth (at least one bit).
    function automatic int unsigned buf_addr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/lisnoc16_usb_tx_pktbuf.sv
// Packet register file for the USB transmit framer: DEPTH x 16 bits,
// one synchronous write port, one asynchronous read port. No reset; contents
// are only read back after being written for the current packet.
// Ports: clk; waddr/wdata/we write port; raddr/rdata combinational read port.
module lisnoc16_usb_tx_pktbuf #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [15:0]       wdata,
    input  logic              we,
    input  logic [ADDR_W-1:0] raddr,
    output logic [15:0]       rdata
);

    localparam int unsigned SLOTS = 2 ** ADDR_W;

    logic [15:0] mem [SLOTS];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous read port
    assign rdata = mem[raddr];

endmodule

// File: rtl/lisnoc16_usb_tx_framer.sv
// Store-and-forward USB transmit framer: collects one 16-bit packet from the
// single-vchannel flit stream, then emits it as bytes:
//   len[7:0], then for each flit content[15:8], content[7:0].
// Optional trailing XOR checksum byte when LISNOC16_USB_TX_CHECKSUM_EN is defined.
// Ports:
//   clk, rst (async, active-low)
//   in_flit/in_valid/in_ready   : flit input, {type[17:16], content[15:0]}
//   out_byte/out_valid/out_ready: byte output to the USB FIFO
//   busy                        : framer not idle
//   err_overflow                : pulse, flit dropped because packet exceeds MAX_PKT_LEN
//   err_proto                   : pulse, PAYLOAD/LAST flit dropped while idle
module lisnoc16_usb_tx_framer
    import lisnoc16_usb_tx_framer_pkg::*;
#(
    parameter int unsigned vchannels    = 1,
    parameter int unsigned use_vchannel = 0,
    parameter int unsigned MAX_PKT_LEN  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [FLIT16_WIDTH-1:0] in_flit,
    input  logic [vchannels-1:0]    in_valid,
    output logic [vchannels-1:0]    in_ready,
    output logic [7:0]              out_byte,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    err_overflow,
    output logic                    err_proto
);

    localparam int unsigned ADDR_W = buf_addr_w(MAX_PKT_LEN);

    if ((MAX_PKT_LEN < 1) || (MAX_PKT_LEN > 255)) begin : g_bad_len
        $error("lisnoc16_usb_tx_framer: MAX_PKT_LEN must be within 1..255");
    end
    if (use_vchannel >= vchannels) begin : g_bad_vc
        $error("lisnoc16_usb_tx_framer: use_vchannel out of range");
    end

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_COLLECT  = 3'd1,
        ST_DROP     = 3'd2,
        ST_SEND_LEN = 3'd3,
        ST_SEND_HI  = 3'd4,
        ST_SEND_LO  = 3'd5
`ifdef LISNOC16_USB_TX_CHECKSUM_EN
        ,
        ST_SEND_CHK = 3'd6
`endif
    } state_e;

    state_e                 state_q, state_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [LEN_WIDTH-1:0]   idx_q, idx_d;
    logic                   rdy_q, rdy_d;
    logic                   err_ov_q, err_ov_d;
    logic                   err_pr_q, err_pr_d;
    logic                   buf_we;
    logic [15:0]            buf_rdata;
    logic                   flit_acc;
    logic                   byte_acc;
    logic                   is_last;
    flit16_t                flit;

    assign flit     = flit16_t'(in_flit);
    assign flit_acc = in_valid[use_vchannel] & rdy_q;
    assign is_last  = (flit.ftype == FLIT16_TYPE_LAST);
    assign byte_acc = out_valid & out_ready;

`ifdef LISNOC16_USB_TX_CHECKSUM_EN
    logic [BYTE_WIDTH-1:0] chk_q;

    // Running XOR of every byte emitted in the current frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chk_q <= '0;
        end else if (state_q == ST_IDLE) begin
            chk_q <= '0;
        end else if (byte_acc) begin
            chk_q <= chk_q ^ out_byte;
        end
    end
`endif

    lisnoc16_usb_tx_pktbuf #(
        .DEPTH  (MAX_PKT_LEN),
        .ADDR_W (ADDR_W)
    ) u_pktbuf (
        .clk   (clk),
        .waddr (ADDR_W'(len_q)),
        .wdata (flit.content),
        .we    (buf_we),
        .raddr (ADDR_W'(idx_q)),
        .rdata (buf_rdata)
    );

    // State and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            idx_q    <= '0;
            rdy_q    <= 1'b0;
            err_ov_q <= 1'b0;
            err_pr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            rdy_q    <= rdy_d;
            err_ov_q <= err_ov_d;
            err_pr_q <= err_pr_d;
        end
    end

    // Next-state, counters and byte decode
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        err_ov_d  = 1'b0;
        err_pr_d  = 1'b0;
        buf_we    = 1'b0;
        out_valid = 1'b0;
        out_byte  = '0;

        case (state_q)
            ST_IDLE: begin
                if (flit_acc) begin
                    case (flit.ftype)
                        FLIT16_TYPE_HEADER: begin
                            buf_we  = 1'b1;
                            len_d   = 8'd1;
                            state_d = ST_COLLECT;
                        end
                        FLIT16_TYPE_SINGLE: begin
                            buf_we  = 1'b1;
                            len_d   = 8'd1;
                            state_d = ST_SEND_LEN;
                        end
                        default: err_pr_d = 1'b1;
                    endcase
                end
            end
            ST_COLLECT: begin
                // HEADER/SINGLE mid-packet are stored as ordinary payload
                if (flit_acc) begin
                    if (len_q == LEN_WIDTH'(MAX_PKT_LEN)) begin
                        err_ov_d = 1'b1;
                        state_d  = is_last ? ST_SEND_LEN : ST_DROP;
                    end else begin
                        buf_we = 1'b1;
                        len_d  = len_q + 8'd1;
                        if (is_last) begin
                            state_d = ST_SEND_LEN;
                        end
                    end
                end
            end
            ST_DROP: begin
                if (flit_acc) begin
                    err_ov_d = 1'b1;
                    if (is_last) begin
                        state_d = ST_SEND_LEN;
                    end
                end
            end
            ST_SEND_LEN: begin
                out_valid = 1'b1;
                out_byte  = len_q;
                if (out_ready) begin
                    state_d = ST_SEND_HI;
                end
            end
            ST_SEND_HI: begin
                out_valid = 1'b1;
                out_byte  = buf_rdata[15:8];
                if (out_ready) begin
                    state_d = ST_SEND_LO;
                end
            end
            ST_SEND_LO: begin
                out_valid = 1'b1;
                out_byte  = buf_rdata[7:0];
                if (out_ready) begin
                    if (idx_q == (len_q - 8'd1)) begin
`ifdef LISNOC16_USB_TX_CHECKSUM_EN
                        state_d = ST_SEND_CHK;
`else
                        state_d = ST_IDLE;
                        len_d   = '0;
                        idx_d   = '0;
`endif
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = ST_SEND_HI;
                    end
                end
            end
`ifdef LISNOC16_USB_TX_CHECKSUM_EN
            ST_SEND_CHK: begin
                out_valid = 1'b1;
                out_byte  = chk_q;
                if (out_ready) begin
                    state_d = ST_IDLE;
                    len_d   = '0;
                    idx_d   = '0;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                len_d   = '0;
                idx_d   = '0;
            end
        endcase

        rdy_d = (state_d == ST_IDLE) || (state_d == ST_COLLECT) || (state_d == ST_DROP);
    end

    // Only the consumed vchannel ever sees ready
    always_comb begin
        in_ready               = '0;
        in_ready[use_vchannel] = rdy_q;
    end

    assign busy         = (state_q != ST_IDLE);
    assign err_overflow = err_ov_q;
    assign err_proto    = err_pr_q;

endmodule
